// File: rtl/axis_sum_pkg.sv
// Shared types and width helpers for the AXI-Stream summing arbiter.
package axis_sum_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Width of the requester index; a single bit even when K is 1 or 2.
  function automatic int id_width(input int k);
    return (k > 2) ? $clog2(k) : 1;
  endfunction

  // Width of the beat counter, wide enough to hold N.
  function automatic int cnt_width(input int n);
    return (n >= 1) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/axis_sum_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int K  = 4,
  parameter int IW = 2
) (
  input  logic [K-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any_req
);

  // Scan K positions starting at ptr; the first hit wins.
  always_comb begin
    int idx;
    gnt_idx = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 0; i < K; i++) begin
      idx = (int'(ptr) + i) % K;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/axis_sum_arbiter.sv
// Round-robin packet arbiter sharing one N-beat AXI-Stream summer among K sources.
// A grant is held for exactly one N-beat packet; beats pass through unmodified
// and are tagged with the granted requester index.
module axis_sum_arbiter
  import axis_sum_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 3,
  parameter int K = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [K-1:0]            s_valid,
  output logic [K-1:0]            s_ready,
  input  logic [K*W-1:0]          s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [W-1:0]            m_data,
  output logic [id_width(K)-1:0]  m_id,
  output logic                    m_last,
  output logic                    busy
);

  localparam int IW = id_width(K);
  localparam int CW = cnt_width(N);

  state_e          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            xfer;
  logic            last_beat;

  rr_pick #(
    .K  (K),
    .IW (IW)
  ) u_pick (
    .req     (s_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any_req (pick_any)
  );

  // Control registers: FSM state, held grant, round-robin pointer, beat count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state logic and the pass-through muxes for the granted source.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    s_ready    = '0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_id       = '0;
    m_last     = 1'b0;
    busy       = 1'b0;
    xfer       = 1'b0;
    last_beat  = (beat_cnt_q == CW'(N - 1));

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        busy             = 1'b1;
        m_id             = grant_q;
        m_valid          = s_valid[grant_q];
        m_data           = s_data[int'(grant_q)*W +: W];
        s_ready[grant_q] = m_ready;
        m_last           = m_valid && last_beat;
        xfer             = m_valid && m_ready;
        if (xfer) begin
          if (last_beat) begin
            // Winner drops to lowest priority for the next round.
            state_d    = IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = (grant_q == IW'(K - 1)) ? '0 : grant_q + 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/axis_sum_arbiter.md
# axis_sum_arbiter

Round-robin scheduler that shares one N-word AXI-Stream summing datapath among K upstream requesters. Grants one requester at a time, holds the grant for exactly one N-beat packet, and forwards its beats unmodified to the summer. Tags every forwarded beat with the requester index so the 7-segment display path can show which source a sum belongs to. Sits between the K source streams and the summer's slave port.

## Interface
Parameters:
- W, 16, data width per beat (matches summer)
- N, 3, beats per packet (matches summer's accumulate count); N ≥ 1
- K, 4, number of requesters; K ≥ 2

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- s_valid  in  K  per-requester valid
- s_ready  out  K  per-requester ready
- s_data  in  K*W  requester i data at bits [i*W +: W]
- m_valid  out  1  valid to summer
- m_ready  in  1  ready from summer
- m_data  out  W  data to summer
- m_id  out  IW  granted requester index, IW = max(1, $clog2(K))
- m_last  out  1  high on the Nth beat of a packet
- busy  out  1  high while a grant is held

## Operation
- Two states: IDLE and BURST.
- IDLE: s_ready all 0, m_valid 0, busy 0. If any s_valid bit is high, pick the first set bit at or after rr_ptr, wrapping K-1→0. Register it into grant, clear beat_cnt, and go to BURST next cycle. If no s_valid bit is high, stay in IDLE.
- BURST: busy 1, m_id = grant.
  - m_valid = s_valid[grant]; m_data = s_data[grant].
  - s_ready[grant] = m_ready; all other s_ready bits are 0.
  - A beat transfers when s_valid[grant] & m_ready; each transfer increments beat_cnt.
  - m_last = m_valid & (beat_cnt == N-1).
  - On the transfer with beat_cnt == N-1: go to IDLE, and set rr_ptr = grant+1 mod K.
- Grant is locked for the full packet. Bubbles (s_valid[grant] low) do not release it. Other requesters' valids are ignored until return to IDLE.
- beat_cnt width is $clog2(N+1). It never exceeds N-1 while in BURST.
- Data is passed through untouched; no arithmetic is performed in this block.

## Timing
- Reset values: state IDLE, rr_ptr 0, grant 0, beat_cnt 0. Outputs: s_ready 0, m_valid 0, m_last 0, m_id 0, busy 0.
- Arbitration latency: 1 cycle from s_valid rising in IDLE to BURST.
- Data path in BURST is combinational, 0 cycles.
- Packet-to-packet gap: exactly 1 IDLE cycle between the last beat of one packet and the first beat of the next.
- Minimum packet duration: N cycles in BURST when the granted source and the summer both stream continuously.
- The summer stalling (m_ready low) stalls only the granted source, which must hold its data (AXIS rule). The arbiter adds no buffering.
- Simultaneous requests in IDLE: the lowest index ≥ rr_ptr wins. The winner gets the lowest priority next round.
- rr_ptr wrap: grant K-1 → rr_ptr 0.
- A requester dropping s_valid in IDLE before it is granted is not an error; it is simply not picked.
- rst asserted mid-BURST: next edge returns to IDLE with reset values, and the partial packet is abandoned. The summer must share the same reset to discard its partial sum. The requester that was mid-packet restarts its packet from beat 0.

## Structure
- Package axis_sum_pkg:
  - state enum (IDLE, BURST)
  - function for IW = max(1, $clog2(K))
  - beat-count width helper
- One sub-module: rr_pick, a combinational round-robin priority picker. Inputs req[K] and ptr. Outputs gnt_idx and any_req.
- Top level holds the FSM, the grant/rr_ptr/beat_cnt registers, and the output muxes.

## Test plan
- Single requester, K=4, N=3: s_valid[2] high with data 5, 6, 7 and m_ready=1. Expect 1 IDLE cycle, then m_id=2 and m_data 5, 6, 7 on consecutive cycles, m_last on 7, then busy falls. Summer outputs sum 18.
- All 4 requesters continuously valid: grant order 0, 1, 2, 3, 0. Each grant is 3 beats with 1 idle cycle between packets.
- Bubble and backpressure: requester 1 granted. s_valid[1] goes low for 2 cycles after beat 1, and m_ready goes low for 3 cycles on beat 2. Grant is held; s_ready[0,2,3] stay 0; exactly 3 transfers occur; m_last is on the third.
- Wrap: rr_ptr=3 with requests on 0 and 3. Expect grant 3, then grant 0.
- Reset mid-packet: assert rst after beat 2 of requester 2. Next cycle: IDLE, all outputs 0, rr_ptr=0. Then requests on 1 and 2 yield grant 1 first.
- N=1, K=2 build: requesters 0 and 1 always valid. Expect alternating single-beat packets, with m_last high on every transfer.
